matmul_seq: RTL

Sequential, parametrised fixed-point matrix multiplier that computes `C = A × B` with one multiply-accumulate per enabled cycle. It succeeds the combinational real-valued `matrix_dot_product`. It adds synthesizable signed fixed-point arithmetic, a start/done handshake, input capture, a stall input, and rounding and saturation. It sits between the layer-weight/activation buffers and the activation stage of the neural-net datapath.

---
 rtl/matmul_pkg.sv | 47 ++++
 rtl/matmul_seq_fixed_mac.sv | 32 +++
 rtl/matmul_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential fixed-point matrix multiplier.
// Rounding/saturation works on a wide signed value so one function serves every parameter set.
package matmul_pkg;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} mm_state_t;

    localparam int SAT_ACC_W = 128;
    localparam int SAT_RES_W = 64;

    typedef struct packed {
        logic [SAT_RES_W-1:0] res;
        logic                 ovf;
    } sat_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int flat_idx(input int row, input int col, input int ncols);
        return row * ncols + col;
    endfunction

    // Round half-up, drop FRAC_W bits, clamp to a signed DATA_W range.
    function automatic sat_t sat_round(input logic signed [SAT_ACC_W-1:0] acc,
                                       input int frac_w, input int data_w);
        logic signed [SAT_ACC_W-1:0] one;
        logic signed [SAT_ACC_W-1:0] r;
        logic signed [SAT_ACC_W-1:0] hi;
        logic signed [SAT_ACC_W-1:0] lo;
        sat_t s;
        one   = 1;
        r     = (acc + (one <<< (frac_w - 1))) >>> frac_w;
        hi    = (one <<< (data_w - 1)) - one;
        lo    = -(one <<< (data_w - 1));
        s.res = r[SAT_RES_W-1:0];
        s.ovf = 1'b0;
        if (r > hi) begin
            s.res = hi[SAT_RES_W-1:0];
            s.ovf = 1'b1;
        end else if (r < lo) begin
            s.res = lo[SAT_RES_W-1:0];
            s.ovf = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/matmul_seq_fixed_mac.sv
// Signed multiply-accumulate. `first` restarts the sum from the current product,
// so consecutive output elements need no bubble cycle.
module fixed_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 33
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     first,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc_sum
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;

    always_comb begin
        prod    = a * b;
        acc_sum = (first ? ACC_W'(0) : acc) + ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (reset || clr)
            acc <= '0;
        else if (en)
            acc <= acc_sum;
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequential fixed-point C = A x B, one MAC per enabled cycle, with start/done handshake.
// state   | meaning
// IDLE    | waiting for start; operands captured on acceptance
// COMPUTE | one MAC per enabled cycle, k innermost, then j, then i
// DONE    | copy result buffer to result_matrix, pulse done
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int M      = 2,
    parameter int K      = 2,
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(K)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start,
    input  logic [M*K*DATA_W-1:0]   matrix_a,
    input  logic [K*N*DATA_W-1:0]   matrix_b,
    output logic                    busy,
    output logic                    done,
    output logic [M*N*DATA_W-1:0]   result_matrix,
    output logic                    overflow
);

    localparam int IW = cnt_w(M);
    localparam int JW = cnt_w(N);
    localparam int KW = cnt_w(K);

    mm_state_t state, state_next;

    logic [IW-1:0] i_cnt;
    logic [JW-1:0] j_cnt;
    logic [KW-1:0] k_cnt;

    logic [M*K*DATA_W-1:0] a_q;
    logic [K*N*DATA_W-1:0] b_q;
    logic [M*N*DATA_W-1:0] res_buf;

    logic accept, mac_en, k_last, j_last, i_last, elem_last;
    logic signed [DATA_W-1:0] a_el, b_el;
    logic signed [ACC_W-1:0]  acc_sum;
    sat_t sr;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable && start) state_next = COMPUTE;
            COMPUTE: if (enable && elem_last) state_next = DONE;
            DONE:    if (enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept    = (state == IDLE) && start && enable;
        mac_en    = (state == COMPUTE) && enable;
        k_last    = (k_cnt == KW'(K - 1));
        j_last    = (j_cnt == JW'(N - 1));
        i_last    = (i_cnt == IW'(M - 1));
        elem_last = k_last && j_last && i_last;
    end

    always_comb begin
        a_el = a_q[flat_idx(int'(i_cnt), int'(k_cnt), K)*DATA_W +: DATA_W];
        b_el = b_q[flat_idx(int'(k_cnt), int'(j_cnt), N)*DATA_W +: DATA_W];
        sr   = sat_round(SAT_ACC_W'(acc_sum), FRAC_W, DATA_W);
    end

    fixed_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk     (clk),
        .reset   (reset),
        .en      (mac_en),
        .clr     (accept),
        .first   (k_cnt == '0),
        .a       (a_el),
        .b       (b_el),
        .acc_sum (acc_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            i_cnt         <= '0;
            j_cnt         <= '0;
            k_cnt         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_buf       <= '0;
            result_matrix <= '0;
            overflow      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else if (enable) begin
            busy <= (state_next != IDLE);
            done <= (state == DONE);
            if (accept) begin
                a_q      <= matrix_a;
                b_q      <= matrix_b;
                i_cnt    <= '0;
                j_cnt    <= '0;
                k_cnt    <= '0;
                overflow <= 1'b0;
            end
            if (state == COMPUTE) begin
                if (k_last) begin
                    res_buf[flat_idx(int'(i_cnt), int'(j_cnt), N)*DATA_W +: DATA_W] <= sr.res[DATA_W-1:0];
                    if (sr.ovf)
                        overflow <= 1'b1;
                    k_cnt <= '0;
                    if (j_last) begin
                        j_cnt <= '0;
                        i_cnt <= i_last ? '0 : i_cnt + 1'b1;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end else begin
                    k_cnt <= k_cnt + 1'b1;
                end
            end
            if (state == DONE)
                result_matrix <= res_buf;
        end
    end

endmodule
